alu_issue_sequencer: RTL and testbench

Multi-cycle control sequencer that accepts 32-bit RISC-V R-type instructions over a valid/ready handshake and drives the register-file/ALU datapath control inputs: the two read register numbers, the write register, the ALU control and the register write enable. It sits between the instruction source and the datapath. It consumes the datapath's `zero_flag` and keeps retire and zero-result statistics.

---
 rtl/riscv_ctrl_pkg.sv | 24 ++
 rtl/rtype_decoder.sv | 33 +++
 rtl/alu_issue_sequencer.sv | 88 ++++++++
 tb/tb_alu_issue_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared RISC-V control definitions: R-type opcode, ALU operation codes
// (also used by the ALU) and the issue-sequencer state encoding.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: maps an instruction word to its ALU
// operation code and a legality flag.
module rtype_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  alu_control,
    output logic        legal
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        alu_control = ALU_ADD;
        legal       = 1'b0;
        if (instr[6:0] == OP_RTYPE) begin
            legal = 1'b1;
            case ({instr[31:25], instr[14:12]})
                {7'b0000000, 3'b000}: alu_control = ALU_ADD;
                {7'b0100000, 3'b000}: alu_control = ALU_SUB;
                {7'b0000000, 3'b111}: alu_control = ALU_AND;
                {7'b0000000, 3'b110}: alu_control = ALU_OR;
                {7'b0000000, 3'b100}: alu_control = ALU_XOR;
                {7'b0000000, 3'b010}: alu_control = ALU_SLT;
                {7'b0000000, 3'b011}: alu_control = ALU_SLTU;
                {7'b0000000, 3'b001}: alu_control = ALU_SLL;
                {7'b0000000, 3'b101}: alu_control = ALU_SRL;
                {7'b0100000, 3'b101}: alu_control = ALU_SRA;
                default:              legal       = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Three-cycle R-type issue sequencer (IDLE -> DECODE -> EXEC) driving the
// register-file/ALU control inputs, with retire and zero-result counters.
module alu_issue_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    input  logic             zero_flag,
    output logic [4:0]       read_reg_num1,
    output logic [4:0]       read_reg_num2,
    output logic [4:0]       write_reg,
    output logic [3:0]       alu_control,
    output logic             regwrite,
    output logic             illegal,
    output logic [CNT_W-1:0] retire_count,
    output logic [CNT_W-1:0] zero_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic       legal_q;
    logic [3:0] dec_alu;
    logic       dec_legal;
    logic       accept;

    rtype_decoder u_decoder (
        .instr       (instr),
        .alu_control (dec_alu),
        .legal       (dec_legal)
    );

    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid && instr_ready;

    // Decoding happens on the handshake edge so the control outputs are
    // already registered when DECODE begins; illegal words leave them untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            legal_q       <= 1'b0;
            read_reg_num1 <= '0;
            read_reg_num2 <= '0;
            write_reg     <= '0;
            alu_control   <= ALU_ADD;
            regwrite      <= 1'b0;
            illegal       <= 1'b0;
            retire_count  <= '0;
            zero_count    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            illegal  <= 1'b0;
            regwrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= DECODE;
                        legal_q <= dec_legal;
                        illegal <= !dec_legal;
                        if (dec_legal) begin
                            read_reg_num1 <= instr[19:15];
                            read_reg_num2 <= instr[24:20];
                            write_reg     <= instr[11:7];
                            alu_control   <= dec_alu;
                        end
                    end
                end
                DECODE: begin
                    state    <= legal_q ? EXEC : IDLE;
                    regwrite <= legal_q && (write_reg != 5'd0);
                end
                EXEC: begin
                    state        <= IDLE;
                    retire_count <= retire_count + CNT_ONE;
                    if (zero_flag && (zero_count != '1))
                        zero_count <= zero_count + CNT_ONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench for alu_issue_sequencer: a 16-bit and a 2-bit counter
// instance share stimulus; expected control values are queued at issue time.
module tb_alu_issue_sequencer;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        zero_flag;

    logic        instr_ready, regwrite, illegal;
    logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
    logic [3:0]  alu_control;
    logic [15:0] retire_count, zero_count;

    logic        s_instr_ready, s_regwrite, s_illegal;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [3:0]  s_alu;
    logic [1:0]  s_retire, s_zero;

    alu_issue_sequencer #(.CNT_W(16)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .zero_flag     (zero_flag),
        .read_reg_num1 (read_reg_num1),
        .read_reg_num2 (read_reg_num2),
        .write_reg     (write_reg),
        .alu_control   (alu_control),
        .regwrite      (regwrite),
        .illegal       (illegal),
        .retire_count  (retire_count),
        .zero_count    (zero_count)
    );

    alu_issue_sequencer #(.CNT_W(2)) u_dut_small (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (s_instr_ready),
        .zero_flag     (zero_flag),
        .read_reg_num1 (s_rs1),
        .read_reg_num2 (s_rs2),
        .write_reg     (s_rd),
        .alu_control   (s_alu),
        .regwrite      (s_regwrite),
        .illegal       (s_illegal),
        .retire_count  (s_retire),
        .zero_count    (s_zero)
    );

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu;
        logic       legal;
    } exp_t;

    exp_t sb[$];

    // {funct7, funct3, alu_control} for every legal R-type operation
    localparam logic [13:0] OP_TABLE [10] = '{
        {7'b0000000, 3'b000, 4'b0010},
        {7'b0100000, 3'b000, 4'b0110},
        {7'b0000000, 3'b111, 4'b0000},
        {7'b0000000, 3'b110, 4'b0001},
        {7'b0000000, 3'b100, 4'b0100},
        {7'b0000000, 3'b010, 4'b0111},
        {7'b0000000, 3'b011, 4'b0011},
        {7'b0000000, 3'b001, 4'b1000},
        {7'b0000000, 3'b101, 4'b1001},
        {7'b0100000, 3'b101, 4'b1010}
    };

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int retired = 0;
    int zeros = 0;
    logic [4:0] last_rs1 = 5'd0, last_rs2 = 5'd0, last_rd = 5'd0;
    logic [3:0] last_alu = 4'b0010;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        e.rs1   = w[19:15];
        e.rs2   = w[24:20];
        e.rd    = w[11:7];
        e.alu   = 4'b0010;
        e.legal = 1'b0;
        if (w[6:0] == 7'b0110011) begin
            for (int i = 0; i < 10; i++) begin
                if (OP_TABLE[i][13:4] == {w[31:25], w[14:12]}) begin
                    e.legal = 1'b1;
                    e.alu   = OP_TABLE[i][3:0];
                end
            end
        end
        return e;
    endfunction

    task automatic check_counters(input string tag);
        int z16;
        int z2;
        z16 = (zeros > 65535) ? 65535 : zeros;
        z2  = (zeros > 3) ? 3 : zeros;
        check({tag, "_retire16"}, 32'(retire_count), 32'(retired % 65536));
        check({tag, "_zero16"},   32'(zero_count),   32'(z16));
        check({tag, "_retire2"},  32'(s_retire),     32'(retired % 4));
        check({tag, "_zero2"},    32'(s_zero),       32'(z2));
    endtask

    // Issue one instruction and follow it through DECODE/EXEC back to IDLE.
    task automatic send(input logic [31:0] w, input logic zf, input bit hold_valid,
                        output int hs_cycle);
        exp_t e;
        int n;
        hs_cycle = -1;
        sb.push_back(model(w));
        @(negedge clock);
        instr       = w;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) begin
            check("ready_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            void'(sb.pop_front());
            return;
        end
        @(posedge clock);
        #1;
        hs_cycle = cyc;
        if (!hold_valid) instr_valid = 1'b0;
        e = sb.pop_front();
        if (e.legal) begin
            last_rs1 = e.rs1;
            last_rs2 = e.rs2;
            last_rd  = e.rd;
            last_alu = e.alu;
        end
        check("dec_rs1",     32'(read_reg_num1), 32'(last_rs1));
        check("dec_rs2",     32'(read_reg_num2), 32'(last_rs2));
        check("dec_rd",      32'(write_reg),     32'(last_rd));
        check("dec_alu",     32'(alu_control),   32'(last_alu));
        check("dec_ready",   32'(instr_ready),   32'd0);
        check("dec_regwrite",32'(regwrite),      32'd0);
        check("dec_illegal", 32'(illegal),       32'(!e.legal));
        @(posedge clock);
        #1;
        if (e.legal) begin
            check("exec_regwrite", 32'(regwrite),    32'(e.rd != 5'd0));
            check("exec_ready",    32'(instr_ready), 32'd0);
            check("exec_illegal",  32'(illegal),     32'd0);
            check("exec_rd",       32'(write_reg),   32'(e.rd));
            zero_flag = zf;
            retired++;
            if (zf) zeros++;
            @(posedge clock);
            #1;
            zero_flag = 1'b0;
        end
        check("idle_ready",    32'(instr_ready), 32'd1);
        check("idle_regwrite", 32'(regwrite),    32'd0);
        check("idle_illegal",  32'(illegal),     32'd0);
        check("idle_alu",      32'(alu_control), 32'(last_alu));
        check_counters("idle");
    endtask

    initial begin
        int hs;
        int prev_hs;
        logic [31:0] b2b [4];
        b2b = '{32'h0020A1B3, 32'h0020B1B3, 32'h002091B3, 32'h0020D1B3};

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        zero_flag   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_alu",   32'(alu_control), 32'b0010);
        check("rst_rs1",   32'(read_reg_num1), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        check("rst_rd",       32'(write_reg), 32'd0);
        check("rst_regwrite", 32'(regwrite),  32'd0);
        check("rst_illegal",  32'(illegal),   32'd0);
        check_counters("rst");

        send(32'h002081B3, 1'b0, 1'b0, hs);   // ADD x3,x1,x2
        send(32'h405282B3, 1'b1, 1'b0, hs);   // SUB x5,x5,x5 with zero result
        send(32'h00208033, 1'b0, 1'b0, hs);   // ADD x0,x1,x2: write suppressed
        send(32'h00000013, 1'b0, 1'b0, hs);   // ADDI: illegal
        send(32'h4020F1B3, 1'b0, 1'b0, hs);   // bad funct7 for AND: illegal
        send(32'h0020F1B3, 1'b1, 1'b0, hs);   // AND
        send(32'h0020E1B3, 1'b0, 1'b0, hs);   // OR
        send(32'h0020C1B3, 1'b0, 1'b0, hs);   // XOR
        send(32'h4020D1B3, 1'b0, 1'b0, hs);   // SRA
        send(32'h002081B2, 1'b0, 1'b0, hs);   // wrong opcode: illegal

        // instr_valid held high: handshakes every 3 cycles
        prev_hs = -1;
        for (int i = 0; i < 4; i++) begin
            send(b2b[i], 1'b0, 1'b1, hs);
            if (prev_hs >= 0) check("b2b_spacing", 32'(hs - prev_hs), 32'd3);
            prev_hs = hs;
        end
        instr_valid = 1'b0;

        // Reset asserted in the middle of EXEC
        @(negedge clock);
        instr       = 32'h002081B3;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        @(posedge clock);
        #1;
        check("mid_exec_regwrite", 32'(regwrite), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_regwrite", 32'(regwrite),      32'd0);
        check("mid_rst_ready",    32'(instr_ready),   32'd1);
        check("mid_rst_rs1",      32'(read_reg_num1), 32'd0);
        check("mid_rst_alu",      32'(alu_control),   32'b0010);
        retired  = 0;
        zeros    = 0;
        last_rs1 = 5'd0;
        last_rs2 = 5'd0;
        last_rd  = 5'd0;
        last_alu = 4'b0010;
        check_counters("mid_rst");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_regwrite", 32'(regwrite), 32'd0);
        check_counters("post_rst");

        // Five zero-result instructions: 2-bit counters saturate / wrap
        for (int i = 0; i < 5; i++) send(32'h405282B3, 1'b1, 1'b0, hs);
        check("small_zero_sat",    32'(s_zero),   32'd3);
        check("small_retire_wrap", 32'(s_retire), 32'd1);
        check("wide_retire",       32'(retire_count), 32'd5);
        check("sb_empty",          32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
